// File: rtl/conv_window_feeder_if.sv
// conv_window_feeder_if: pixel-stream input and 3x3 window output handshakes of the feeder.
interface conv_window_feeder_if #(parameter int SIZE = 23);
    logic [SIZE-1:0] pix_in;
    logic            pix_valid;
    logic            pix_ready;
    logic [SIZE-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic            win_valid;
    logic            win_ready;
    logic            frame_done;

    modport master (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, w1, w2, w3, w4, w5, w6, w7, w8, w9, win_valid, frame_done
    );

    modport slave (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, w1, w2, w3, w4, w5, w6, w7, w8, w9, win_valid, frame_done
    );
endinterface

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: buffers two image lines and streams 3x3 windows from a raster pixel stream.
// Define CONV_STRIDE2_EN to emit only stride-2 windows.
module conv_window_feeder #(
    parameter int SIZE  = 23,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input logic clk,
    input logic rst,
    conv_window_feeder_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {S_FILL, S_RUN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [SIZE-1:0] lb0 [IMG_W];
    logic [SIZE-1:0] lb1 [IMG_W];
    logic            accept, col_last, row_last, emit_ok, qual;

    assign bus.pix_ready = !bus.win_valid || bus.win_ready;
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign col_last      = col == CW'(IMG_W - 1);
    assign row_last      = row == RW'(IMG_H - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_FILL;
        else     state <= state_nxt;

    always_comb
        state_nxt = !(accept && col_last) ? state :
                    row == RW'(1)         ? S_RUN :
                    row_last              ? S_FILL : state;

    // S_RUN already implies row >= 2, so only the column gate remains
    always_comb begin
        emit_ok = state == S_RUN;
`ifdef CONV_STRIDE2_EN
        qual = emit_ok && col >= CW'(2) && !row[0] && !col[0];
`else
        qual = emit_ok && col >= CW'(2);
`endif
    end

    always_ff @(posedge clk)
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.pix_in;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {bus.w1, bus.w2, bus.w3} <= '0;
            {bus.w4, bus.w5, bus.w6} <= '0;
            {bus.w7, bus.w8, bus.w9} <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            row <= '0;
            col <= '0;
        end else begin
            bus.frame_done <= accept && col_last && row_last;
            bus.win_valid  <= accept ? qual : bus.win_valid && !bus.win_ready;
            if (accept) begin
                {bus.w1, bus.w2, bus.w3} <= {bus.w2, bus.w3, lb1[col]};
                {bus.w4, bus.w5, bus.w6} <= {bus.w5, bus.w6, lb0[col]};
                {bus.w7, bus.w8, bus.w9} <= {bus.w8, bus.w9, bus.pix_in};
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) row <= row_last ? '0 : row + RW'(1);
            end
        end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: directed frames checking windows, stalls, gaps, mid-frame reset and frame wrap.
module tb_conv_window_feeder;
    localparam int SIZE = 23;
`ifdef CONV_STRIDE2_EN
    localparam int W = 5;
    localparam int H = 5;
    int tls [4] = '{1, 3, 11, 13};
`else
    localparam int W = 4;
    localparam int H = 4;
    int tls [4] = '{1, 2, 5, 6};
`endif

    logic clk, rst;
    int total = 0, bad = 0, nwin = 0, nfd = 0;
    int n0, f0;
    logic [255:0] taps;
    logic [255:0] exp_q [$];

    conv_window_feeder_if #(.SIZE(SIZE)) bus ();
    conv_window_feeder #(.SIZE(SIZE), .IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign taps = {{(256 - 9 * SIZE){1'b0}}, bus.w1, bus.w2, bus.w3, bus.w4, bus.w5, bus.w6, bus.w7, bus.w8, bus.w9};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] win(input int tl);
        logic [255:0] r = '0;
        for (int j = 0; j < 9; j++) r = (r << SIZE) | 256'(tl + (j / 3) * W + j % 3);
        return r;
    endfunction

    function automatic bit qual(input int i);
        int r = i / W, c = i % W;
`ifdef CONV_STRIDE2_EN
        return r >= 2 && c >= 2 && r % 2 == 0 && c % 2 == 0;
`else
        return r >= 2 && c >= 2;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.win_valid && bus.win_ready) begin
            nwin++;
            if (exp_q.size() == 0) chk("extra_win", 256'(1), 256'(0));
            else chk("win", taps, exp_q.pop_front());
        end
        if (!rst && bus.frame_done) nfd++;
    end

    task automatic push_frame(input int base);
        for (int k = 0; k < 4; k++) exp_q.push_back(win(base + tls[k]));
    endtask

    task automatic send(input int v, input int i);
        int n = 0;
        bus.pix_in = SIZE'(v);
        bus.pix_valid = 1'b1;
        while (!bus.pix_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1 bus.pix_valid = 1'b0;
        @(negedge clk);
        chk("win_valid", 256'(bus.win_valid), 256'(qual(i)));
        chk("frame_done", 256'(bus.frame_done), 256'(i == W * H - 1));
    endtask

    task automatic frame(input int base, input bit gap);
        for (int i = 0; i < W * H; i++) begin
            send(base + i + 1, i);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic stall();
        int n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!bus.win_valid && n < 200);
        if (!bus.win_valid) chk("stall_timeout", 256'(0), 256'(1));
        bus.win_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_ready", 256'(bus.pix_ready), 256'(0));
            chk("stall_hold", taps, win(tls[0]));
        end
        @(posedge clk);
        #1 bus.win_ready = 1'b1;
    endtask

    task automatic scn_start();
        n0 = nwin;
        f0 = nfd;
    endtask

    task automatic scn_end(input string tag, input int wins, input int fds);
        repeat (3) @(negedge clk);
        chk({tag, "_wins"}, 256'(nwin - n0), 256'(wins));
        chk({tag, "_fds"}, 256'(nfd - f0), 256'(fds));
        chk({tag, "_left"}, 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        clk = 0;
        rst = 0;
        bus.pix_valid = 0;
        bus.pix_in = '0;
        bus.win_ready = 1;
        #1 rst = 1;
        #1;
        chk("rst_taps", taps, 256'(0));
        chk("rst_win_valid", 256'(bus.win_valid), 256'(0));
        chk("rst_frame_done", 256'(bus.frame_done), 256'(0));
        chk("rst_pix_ready", 256'(bus.pix_ready), 256'(1));
        #10 rst = 0;
        @(negedge clk);

        scn_start();
        push_frame(0);
        frame(0, 0);
        scn_end("basic", 4, 1);

        scn_start();
        push_frame(0);
        fork
            frame(0, 0);
            stall();
        join
        scn_end("stall", 4, 1);

        scn_start();
        push_frame(0);
        frame(0, 1);
        scn_end("gap", 4, 1);

        for (int i = 0; i < 9; i++) send(i + 1, i);
        #1 rst = 1;
        #1;
        chk("mid_rst_taps", taps, 256'(0));
        chk("mid_rst_win_valid", 256'(bus.win_valid), 256'(0));
        chk("mid_rst_frame_done", 256'(bus.frame_done), 256'(0));
        #1 rst = 0;
        @(negedge clk);
        scn_start();
        push_frame(0);
        frame(0, 0);
        scn_end("after_rst", 4, 1);

        scn_start();
        push_frame(0);
        push_frame(W * H);
        frame(0, 0);
        frame(W * H, 0);
        scn_end("b2b", 8, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
